// File: rtl/dmem_port_arbiter.sv
// Arbiter for the single-port data memory shared by the MEM stage, the user debug port and
// the EDC injection port. Each access runs issue -> fixed-latency wait -> response.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PAR_W      = 7,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_din,
  output logic              pipe_stall,
  output logic              pipe_rvalid,
  output logic [DATA_W-1:0] pipe_dout,
  input  logic              user_req,
  input  logic              user_we,
  input  logic [ADDR_W-1:0] user_addr,
  input  logic [DATA_W-1:0] user_din,
  output logic              user_ack,
  output logic [DATA_W-1:0] user_dout,
  input  logic              edc_req,
  input  logic              edc_dwe,
  input  logic              edc_pwe,
  input  logic [8:0]        edc_addr,
  input  logic [DATA_W-1:0] edc_din,
  input  logic [PAR_W-1:0]  edc_pin,
  output logic              edc_ack,
  output logic [DATA_W-1:0] edc_dout,
  output logic [PAR_W-1:0]  edc_pout,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_pwe,
  output logic              mem_raw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [PAR_W-1:0]  mem_pin,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic [PAR_W-1:0]  mem_pout
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
  typedef enum logic [1:0] {WinPipe, WinUser, WinEdc} win_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
  localparam logic [2:0] LatLoad   = 3'(MEM_LAT);

  state_e              state_q, state_d;
  win_e                win_q, win_d, grant;
  logic                wr_q, wr_d;
  logic [2:0]          lat_q, lat_d;
  logic [3:0]          edc_cnt_q, edc_cnt_d, user_cnt_q, user_cnt_d;
  logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic                mem_pwe_q, mem_pwe_d, mem_raw_q, mem_raw_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic [PAR_W-1:0]    mem_pin_q, mem_pin_d;
  logic [DATA_W-1:0]   pipe_dout_q, pipe_dout_d, user_dout_q, user_dout_d;
  logic [DATA_W-1:0]   edc_dout_q, edc_dout_d;
  logic [PAR_W-1:0]    edc_pout_q, edc_pout_d;
  logic                pipe_rvalid_q, pipe_rvalid_d, user_ack_q, user_ack_d;
  logic                edc_ack_q, edc_ack_d;

  // Starved requesters jump ahead of the pipeline; edc is checked first.
  always_comb begin
    if (edc_req && edc_cnt_q == StarveMax)        grant = WinEdc;
    else if (user_req && user_cnt_q == StarveMax) grant = WinUser;
    else if (pipe_req)                            grant = WinPipe;
    else if (edc_req)                             grant = WinEdc;
    else                                          grant = WinUser;
  end

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    wr_d          = wr_q;
    lat_d         = lat_q;
    edc_cnt_d     = edc_cnt_q;
    user_cnt_d    = user_cnt_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_pwe_d     = 1'b0;
    mem_raw_d     = 1'b0;
    mem_addr_d    = '0;
    mem_din_d     = '0;
    mem_pin_d     = '0;
    pipe_dout_d   = pipe_dout_q;
    user_dout_d   = user_dout_q;
    edc_dout_d    = edc_dout_q;
    edc_pout_d    = edc_pout_q;
    pipe_rvalid_d = 1'b0;
    user_ack_d    = 1'b0;
    edc_ack_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pipe_req || user_req || edc_req) begin
          state_d  = StIssue;
          win_d    = grant;
          mem_en_d = 1'b1;
          if (grant == WinEdc)                         edc_cnt_d = '0;
          else if (edc_req && edc_cnt_q < StarveMax)   edc_cnt_d = edc_cnt_q + 4'd1;
          if (grant == WinUser)                        user_cnt_d = '0;
          else if (user_req && user_cnt_q < StarveMax) user_cnt_d = user_cnt_q + 4'd1;
          unique case (grant)
            WinEdc: begin
              mem_we_d   = edc_dwe;
              mem_pwe_d  = edc_pwe;
              mem_raw_d  = 1'b1;
              mem_addr_d = ADDR_W'(edc_addr);
              mem_din_d  = edc_din;
              mem_pin_d  = edc_pin;
            end
            WinUser: begin
              mem_we_d   = user_we;
              mem_addr_d = user_addr;
              mem_din_d  = user_din;
            end
            default: begin
              mem_we_d   = pipe_we;
              mem_addr_d = pipe_addr;
              mem_din_d  = pipe_din;
            end
          endcase
          wr_d = mem_we_d | mem_pwe_d;
        end
      end
      StIssue: begin
        lat_d   = LatLoad;
        state_d = StWait;
      end
      StWait: begin
        if (lat_q <= 3'd1) begin
          state_d = StResp;
          // Writes leave a zero in the winner's read-data register.
          unique case (win_q)
            WinEdc: begin
              edc_ack_d  = 1'b1;
              edc_dout_d = wr_q ? '0 : mem_dout;
              edc_pout_d = wr_q ? '0 : mem_pout;
            end
            WinUser: begin
              user_ack_d  = 1'b1;
              user_dout_d = wr_q ? '0 : mem_dout;
            end
            default: begin
              pipe_rvalid_d = 1'b1;
              pipe_dout_d   = wr_q ? '0 : mem_dout;
            end
          endcase
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      win_q         <= WinPipe;
      wr_q          <= 1'b0;
      lat_q         <= '0;
      edc_cnt_q     <= '0;
      user_cnt_q    <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_pwe_q     <= 1'b0;
      mem_raw_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      mem_pin_q     <= '0;
      pipe_dout_q   <= '0;
      user_dout_q   <= '0;
      edc_dout_q    <= '0;
      edc_pout_q    <= '0;
      pipe_rvalid_q <= 1'b0;
      user_ack_q    <= 1'b0;
      edc_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      wr_q          <= wr_d;
      lat_q         <= lat_d;
      edc_cnt_q     <= edc_cnt_d;
      user_cnt_q    <= user_cnt_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_pwe_q     <= mem_pwe_d;
      mem_raw_q     <= mem_raw_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      mem_pin_q     <= mem_pin_d;
      pipe_dout_q   <= pipe_dout_d;
      user_dout_q   <= user_dout_d;
      edc_dout_q    <= edc_dout_d;
      edc_pout_q    <= edc_pout_d;
      pipe_rvalid_q <= pipe_rvalid_d;
      user_ack_q    <= user_ack_d;
      edc_ack_q     <= edc_ack_d;
    end
  end

  assign pipe_stall  = pipe_req & ~rst & ~(state_q == StResp && win_q == WinPipe);
  assign pipe_rvalid = pipe_rvalid_q;
  assign pipe_dout   = pipe_dout_q;
  assign user_ack    = user_ack_q;
  assign user_dout   = user_dout_q;
  assign edc_ack     = edc_ack_q;
  assign edc_dout    = edc_dout_q;
  assign edc_pout    = edc_pout_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_pwe     = mem_pwe_q;
  assign mem_raw     = mem_raw_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_pin     = mem_pin_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each backed by a small memory model that returns junk outside its valid read cycle.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance with MEM_LAT=1
  logic        pipe_req = 0, pipe_we = 0, pipe_stall, pipe_rvalid;
  logic [12:0] pipe_addr = '0;
  logic [31:0] pipe_din = '0, pipe_dout;
  logic        user_req = 0, user_we = 0, user_ack;
  logic [12:0] user_addr = '0;
  logic [31:0] user_din = '0, user_dout;
  logic        edc_req = 0, edc_dwe = 0, edc_pwe = 0, edc_ack;
  logic [8:0]  edc_addr = '0;
  logic [31:0] edc_din = '0, edc_dout;
  logic [6:0]  edc_pin = '0, edc_pout;
  logic        mem_en, mem_we, mem_pwe, mem_raw;
  logic [12:0] mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic [6:0]  mem_pin, mem_pout;

  // Instance with MEM_LAT=3 (pipe port only exercised)
  logic        l3_pipe_req = 0, l3_pipe_we = 0, l3_pipe_stall, l3_pipe_rvalid;
  logic [12:0] l3_pipe_addr = '0;
  logic [31:0] l3_pipe_din = '0, l3_pipe_dout;
  logic        l3_user_ack, l3_edc_ack;
  logic [31:0] l3_user_dout, l3_edc_dout;
  logic [6:0]  l3_edc_pout;
  logic        l3_mem_en, l3_mem_we, l3_mem_pwe, l3_mem_raw;
  logic [12:0] l3_mem_addr;
  logic [31:0] l3_mem_din, l3_mem_dout;
  logic [6:0]  l3_mem_pin, l3_mem_pout;

  dmem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(8)) u_dut (
    .clk(clk), .rst(rst),
    .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_din(pipe_din),
    .pipe_stall(pipe_stall), .pipe_rvalid(pipe_rvalid), .pipe_dout(pipe_dout),
    .user_req(user_req), .user_we(user_we), .user_addr(user_addr), .user_din(user_din),
    .user_ack(user_ack), .user_dout(user_dout),
    .edc_req(edc_req), .edc_dwe(edc_dwe), .edc_pwe(edc_pwe), .edc_addr(edc_addr),
    .edc_din(edc_din), .edc_pin(edc_pin), .edc_ack(edc_ack), .edc_dout(edc_dout),
    .edc_pout(edc_pout),
    .mem_en(mem_en), .mem_we(mem_we), .mem_pwe(mem_pwe), .mem_raw(mem_raw),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_pin(mem_pin),
    .mem_dout(mem_dout), .mem_pout(mem_pout)
  );

  dmem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(8)) u_dut3 (
    .clk(clk), .rst(rst),
    .pipe_req(l3_pipe_req), .pipe_we(l3_pipe_we), .pipe_addr(l3_pipe_addr),
    .pipe_din(l3_pipe_din), .pipe_stall(l3_pipe_stall), .pipe_rvalid(l3_pipe_rvalid),
    .pipe_dout(l3_pipe_dout),
    .user_req(1'b0), .user_we(1'b0), .user_addr(13'h0), .user_din(32'h0),
    .user_ack(l3_user_ack), .user_dout(l3_user_dout),
    .edc_req(1'b0), .edc_dwe(1'b0), .edc_pwe(1'b0), .edc_addr(9'h0),
    .edc_din(32'h0), .edc_pin(7'h0), .edc_ack(l3_edc_ack), .edc_dout(l3_edc_dout),
    .edc_pout(l3_edc_pout),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_pwe(l3_mem_pwe), .mem_raw(l3_mem_raw),
    .mem_addr(l3_mem_addr), .mem_din(l3_mem_din), .mem_pin(l3_mem_pin),
    .mem_dout(l3_mem_dout), .mem_pout(l3_mem_pout)
  );

  function automatic logic [6:0] par_fn(input logic [31:0] d);
    return d[6:0] ^ d[13:7] ^ d[20:14] ^ d[27:21] ^ {3'b000, d[31:28]};
  endfunction

  // Memory model, latency 1
  logic [31:0] m_d [8192];
  logic [6:0]  m_p [8192];
  logic [31:0] r_d;
  logic [6:0]  r_p;
  logic        r_v;
  always @(posedge clk) begin
    if (rst) begin
      m_d[13'h010] <= 32'h1111_1111;
      m_d[13'h020] <= 32'h2222_2222;
      m_p[13'h020] <= 7'h15;
      m_d[13'h030] <= 32'h3333_3333;
      m_p[13'h1FF] <= 7'h2B;
    end
    r_v <= 1'b0;
    if (mem_en) begin
      if (mem_we) m_d[mem_addr] <= mem_din;
      if (mem_raw) begin
        if (mem_pwe) m_p[mem_addr] <= mem_pin;
      end else if (mem_we) begin
        m_p[mem_addr] <= par_fn(mem_din);
      end
      r_d <= m_d[mem_addr];
      r_p <= m_p[mem_addr];
      r_v <= !mem_we && !mem_pwe;
    end
  end
  assign mem_dout = r_v ? r_d : 32'hBAD0_BAD0;
  assign mem_pout = r_v ? r_p : 7'h6A;

  // Memory model, latency 3
  logic [31:0] m3_d [8192];
  logic [31:0] s3_d [3];
  logic [2:0]  s3_v;
  always @(posedge clk) begin
    if (rst) m3_d[13'h040] <= 32'hCAFE_F00D;
    if (l3_mem_en && l3_mem_we) m3_d[l3_mem_addr] <= l3_mem_din;
    s3_d[0] <= m3_d[l3_mem_addr];
    s3_d[1] <= s3_d[0];
    s3_d[2] <= s3_d[1];
    s3_v    <= {s3_v[1:0], l3_mem_en && !l3_mem_we};
  end
  assign l3_mem_dout = s3_v[2] ? s3_d[2] : 32'hBAD0_BAD0;
  assign l3_mem_pout = 7'h00;

  task automatic test_reset();
    rst = 1'b1;
    pipe_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (pipe_stall !== 1'b0) begin errors++;
      $display("FAIL rst_stall: got %b want 0", pipe_stall); end
    checks++; if ({mem_en, mem_we, mem_pwe, mem_raw, mem_addr} !== '0) begin errors++;
      $display("FAIL rst_mem: got en=%b addr=%h want 0", mem_en, mem_addr); end
    checks++; if ({pipe_rvalid, user_ack, edc_ack} !== 3'b000) begin errors++;
      $display("FAIL rst_acks: got %b want 000", {pipe_rvalid, user_ack, edc_ack}); end
    checks++; if ({pipe_dout, user_dout, edc_dout, edc_pout} !== '0) begin errors++;
      $display("FAIL rst_dout: got %h want 0", pipe_dout); end
    pipe_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pipe_wr_rd();
    int n;
    @(negedge clk);
    pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 13'h0040; pipe_din = 32'hDEAD_BEEF;
    #1;
    checks++; if (pipe_stall !== 1'b1) begin errors++;
      $display("FAIL wr_stall_c0: got %b want 1", pipe_stall); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++; if ({mem_en, mem_we, mem_pwe, mem_raw} !== 4'b1100) begin errors++;
          $display("FAIL wr_cmd: got %b want 1100", {mem_en, mem_we, mem_pwe, mem_raw}); end
        checks++; if (mem_addr !== 13'h0040 || mem_din !== 32'hDEAD_BEEF || mem_pin !== 7'h0)
        begin errors++;
          $display("FAIL wr_fields: got %h/%h/%h", mem_addr, mem_din, mem_pin); end
      end
      if (c == 2) begin
        checks++; if (mem_en !== 1'b0 || mem_addr !== 13'h0) begin errors++;
          $display("FAIL wr_idle_cmd: got en=%b addr=%h want 0", mem_en, mem_addr); end
      end
      checks++; if (pipe_rvalid !== (c == 3)) begin errors++;
        $display("FAIL wr_rvalid c%0d: got %b want %b", c, pipe_rvalid, c == 3); end
      checks++; if (pipe_stall !== (c != 3)) begin errors++;
        $display("FAIL wr_stall c%0d: got %b want %b", c, pipe_stall, c != 3); end
    end
    pipe_req = 1'b0; pipe_we = 1'b0;
    @(negedge clk);
    pipe_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!pipe_rvalid && n < 20);
    checks++; if (n !== 3) begin errors++;
      $display("FAIL rd_latency: got %0d want 3", n); end
    checks++; if (pipe_dout !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL rd_data: got %h want deadbeef", pipe_dout); end
    pipe_req = 1'b0;
  endtask

  task automatic test_simultaneous();
    int tp = -1, te = -1, tu = -1, multi = 0;
    @(negedge clk);
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 13'h010;
    user_req = 1'b1; user_we = 1'b0; user_addr = 13'h030;
    edc_req = 1'b1; edc_dwe = 1'b0; edc_pwe = 1'b0; edc_addr = 9'h020;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (int'(pipe_rvalid) + int'(user_ack) + int'(edc_ack) > 1) multi++;
      if (pipe_rvalid) begin tp = c; pipe_req = 1'b0;
        checks++; if (pipe_dout !== 32'h1111_1111) begin errors++;
          $display("FAIL sim_pipe_data: got %h want 11111111", pipe_dout); end
      end
      if (edc_ack) begin te = c; edc_req = 1'b0;
        checks++; if (edc_dout !== 32'h2222_2222 || edc_pout !== 7'h15) begin errors++;
          $display("FAIL sim_edc_data: got %h/%h want 22222222/15", edc_dout, edc_pout); end
      end
      if (user_ack) begin tu = c; user_req = 1'b0;
        checks++; if (user_dout !== 32'h3333_3333) begin errors++;
          $display("FAIL sim_user_data: got %h want 33333333", user_dout); end
      end
    end
    pipe_req = 1'b0; edc_req = 1'b0; user_req = 1'b0;
    checks++; if (tp !== 3 || te !== 7 || tu !== 11) begin errors++;
      $display("FAIL sim_order: got p%0d e%0d u%0d want p3 e7 u11", tp, te, tu); end
    checks++; if (multi !== 0) begin errors++;
      $display("FAIL sim_one_ack: got %0d cycles with >1 ack want 0", multi); end
  endtask

  task automatic test_starvation();
    int np = 0, nu = 0, pc0 = -1, pc1 = -1;
    bit got_next = 0, next_pipe = 0;
    @(negedge clk);
    pipe_req = 1'b1; pipe_addr = 13'h040; user_req = 1'b1; user_addr = 13'h030;
    for (int c = 0; c < 200 && !got_next; c++) begin
      @(negedge clk);
      if (nu == 2 && (pipe_rvalid || user_ack)) begin
        got_next = 1; next_pipe = pipe_rvalid; pipe_req = 1'b0;
      end else begin
        if (pipe_rvalid) np++;
        if (user_ack) begin
          if (nu == 0) pc0 = np; else pc1 = np;
          np = 0; nu++;
          if (nu == 2) user_req = 1'b0;
        end
      end
    end
    pipe_req = 1'b0; user_req = 1'b0;
    checks++; if (pc0 !== 8) begin errors++;
      $display("FAIL starve_first: got %0d pipe wins want 8", pc0); end
    checks++; if (pc1 !== 8) begin errors++;
      $display("FAIL starve_cleared: got %0d pipe wins want 8", pc1); end
    checks++; if (!got_next || !next_pipe) begin errors++;
      $display("FAIL starve_resume: got seen=%b pipe=%b want 1/1", got_next, next_pipe); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_edc_inject();
    int n;
    @(negedge clk);
    edc_req = 1'b1; edc_dwe = 1'b1; edc_pwe = 1'b0; edc_addr = 9'h1FF;
    edc_din = 32'h0000_0001; edc_pin = 7'h7F;
    @(negedge clk);
    checks++; if ({mem_en, mem_raw, mem_we, mem_pwe} !== 4'b1110) begin errors++;
      $display("FAIL edc_cmd: got %b want 1110", {mem_en, mem_raw, mem_we, mem_pwe}); end
    checks++; if (mem_addr !== 13'h01FF || mem_din !== 32'h1 || mem_pin !== 7'h7F) begin
      errors++; $display("FAIL edc_fields: got %h/%h/%h", mem_addr, mem_din, mem_pin); end
    repeat (2) @(negedge clk);
    checks++; if (edc_ack !== 1'b1 || edc_dout !== 32'h0 || edc_pout !== 7'h0) begin errors++;
      $display("FAIL edc_wr_ack: got %b %h %h want 1 0 0", edc_ack, edc_dout, edc_pout); end
    edc_req = 1'b0; edc_dwe = 1'b0;
    @(negedge clk);
    edc_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!edc_ack && n < 20);
    checks++; if (n !== 3 || edc_dout !== 32'h1 || edc_pout !== 7'h2B) begin errors++;
      $display("FAIL edc_rd: got n=%0d %h %h want 3 1 2b", n, edc_dout, edc_pout); end
    edc_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 13'h040;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (pipe_stall !== 1'b0 || mem_en !== 1'b0) begin errors++;
      $display("FAIL rstmid_now: got stall=%b en=%b want 0 0", pipe_stall, mem_en); end
    @(negedge clk);
    checks++; if ({pipe_rvalid, user_ack, edc_ack, mem_en, pipe_stall} !== 5'b0) begin
      errors++; $display("FAIL rstmid_held: got %b want 0",
                         {pipe_rvalid, user_ack, edc_ack, mem_en, pipe_stall}); end
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!pipe_rvalid && n < 20);
    checks++; if (n !== 3 || pipe_dout !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL rstmid_fresh: got n=%0d %h want 3 deadbeef", n, pipe_dout); end
    pipe_req = 1'b0;
  endtask

  task automatic test_memlat3();
    int n;
    @(negedge clk);
    l3_pipe_req = 1'b1; l3_pipe_we = 1'b0; l3_pipe_addr = 13'h040;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++; if (l3_mem_en !== 1'b1) begin errors++;
          $display("FAIL lat3_issue: got %b want 1", l3_mem_en); end
      end
      checks++; if (l3_pipe_rvalid !== (c == 5)) begin errors++;
        $display("FAIL lat3_rvalid c%0d: got %b want %b", c, l3_pipe_rvalid, c == 5); end
    end
    checks++; if (l3_pipe_dout !== 32'hCAFE_F00D || l3_pipe_stall !== 1'b0) begin errors++;
      $display("FAIL lat3_data: got %h stall=%b want cafef00d 0", l3_pipe_dout, l3_pipe_stall);
    end
    l3_pipe_req = 1'b0;
    @(negedge clk);
    l3_pipe_req = 1'b1; l3_pipe_we = 1'b1; l3_pipe_addr = 13'h044; l3_pipe_din = 32'h1234_5678;
    n = 0;
    do begin @(negedge clk); n++; end while (!l3_pipe_rvalid && n < 20);
    checks++; if (n !== 5 || l3_pipe_dout !== 32'h0) begin errors++;
      $display("FAIL lat3_wr: got n=%0d %h want 5 0", n, l3_pipe_dout); end
    checks++; if ({l3_user_ack, l3_edc_ack, l3_user_dout, l3_edc_dout, l3_edc_pout} !== '0)
    begin errors++; $display("FAIL lat3_idle_ports: got %b %b want 0 0", l3_user_ack,
                             l3_edc_ack); end
    l3_pipe_req = 1'b0; l3_pipe_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pipe_wr_rd();
    test_simultaneous();
    test_starvation();
    test_edc_inject();
    test_reset_mid();
    test_memlat3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Arbitrates the single-port data memory (with parity array) among three requesters:
  - the pipeline MEM stage,
  - the user debug port,
  - the EDC error-injection port.
- Sequences each access as issue, fixed-latency wait and response.
- Drives the pipeline stall (isCacheStall source) while a MEM-stage access is outstanding.
- Sits between the MEM stage/top-level ports and the memory wrapper.

Parameters:
- ADDR_W, 13, memory word-address width
- DATA_W, 32, data width
- PAR_W, 7, parity width
- MEM_LAT, 1, memory read latency in cycles, from the cycle mem_en is high to the cycle mem_dout is valid; legal range 1..7
- STARVE_MAX, 8, lost arbitrations after which a waiting user/EDC requester is promoted; legal range 1..15

Ports:
- clk in 1: clock.
- rst in 1: asynchronous active-high reset.
- pipe_req in 1, pipe_we in 1, pipe_addr in ADDR_W, pipe_din in DATA_W: MEM-stage request.
- pipe_stall out 1: MEM-stage access outstanding; freezes pipeline.
- pipe_rvalid out 1, pipe_dout out DATA_W: MEM-stage completion pulse and read data.
- user_req in 1, user_we in 1, user_addr in ADDR_W, user_din in DATA_W: user port request.
- user_ack out 1, user_dout out DATA_W: user completion pulse and read data.
- edc_req in 1, edc_dwe in 1, edc_pwe in 1, edc_addr in 9, edc_din in DATA_W, edc_pin in PAR_W: EDC request.
  - edc_addr is zero-extended to ADDR_W.
- edc_ack out 1, edc_dout out DATA_W, edc_pout out PAR_W: EDC completion pulse and read data/parity.
- mem_en out 1, mem_we out 1, mem_pwe out 1, mem_raw out 1, mem_addr out ADDR_W, mem_din out DATA_W, mem_pin out PAR_W: memory command.
  - mem_raw=1 means the wrapper bypasses its parity encoder.
- mem_dout in DATA_W, mem_pout in PAR_W: memory read data/parity.

Behaviour:
- Single clock clk. Reset rst is asynchronous, active-high. All state and registered outputs are 0 in reset; pipe_stall is forced 0 while rst is high.
- FSM states:
  - IDLE: arbitrate. Any request → ISSUE; latch winner id, we flags, addr, din, pin.
  - ISSUE: one cycle. mem_en=1 with latched command; wait counter loaded with MEM_LAT → WAIT.
  - WAIT: counter decrements each cycle. On the cycle it reaches 1, capture mem_dout/mem_pout into the winner's dout registers → RESP.
  - RESP: one cycle. Winner's ack/rvalid=1 → IDLE.
- Latency: grant in cycle 0 → ack in cycle MEM_LAT+2. Minimum spacing between grants is MEM_LAT+3 cycles.
- Requests are sampled only in IDLE. Command fields are latched at grant; later changes to them are ignored.
- Requester holds req until its ack. If req drops mid-access, the access still completes and ack still pulses.
- Arbitration priority: pipe > edc > user, with starvation override.
  - Per-requester 4-bit wait counters for edc and user.
  - A counter increments when its requester is requesting in IDLE and loses.
  - A counter clears when its requester is granted.
  - A counter saturates at STARVE_MAX.
  - Any counter at STARVE_MAX wins over pipe; edc first if both are at STARVE_MAX.
- Command mapping:
  - pipe/user: mem_we=*_we, mem_pwe=0, mem_raw=0, mem_pin=0.
  - edc: mem_we=edc_dwe, mem_pwe=edc_pwe, mem_raw=1. dwe=pwe=0 is a read of data+parity.
- Read data: dout registers update only for reads. Write accesses clear the winner's dout (and edc_pout) to 0.
- pipe_stall = pipe_req AND NOT (state==RESP AND winner==pipe). It is combinational and drops in the same cycle pipe_rvalid pulses.
- Outputs with no access active: mem_en=0 and all mem_* command outputs are 0 outside ISSUE.
- Only one ack/rvalid is ever high in a cycle.
- Reset mid-operation: FSM returns to IDLE and the in-flight access is abandoned. No ack is issued and counters clear; the requester must re-request.

Test Plan:
- Pipe write then read: write 0xDEADBEEF to addr 0x0040 with MEM_LAT=1. Expected:
  - pipe_rvalid in cycle 3 after grant;
  - pipe_stall high cycles 0-2, low in cycle 3;
  - the read then returns pipe_dout=0xDEADBEEF.
- Simultaneous requests: pipe, user and edc all assert in the same IDLE cycle.
  - Expected grant order: pipe, edc, user.
  - Only one ack per cycle; grants spaced 4 cycles apart.
- Starvation: pipe_req held continuously, user_req high, STARVE_MAX=8. User is granted on the 9th arbitration; its counter clears; pipe resumes next.
- EDC injection:
  - edc_dwe=1, edc_pwe=0, addr 0x1FF, din 0x00000001. Expected mem_raw=1, mem_we=1, mem_pwe=0, mem_addr=0x01FF.
  - EDC read of the same address returns edc_dout=0x00000001 and edc_pout equal to mem_pout.
- Reset mid-access: assert rst during WAIT. Expected:
  - mem_en=0, no ack, state IDLE, pipe_stall=0;
  - after release with pipe_req held, a fresh access completes normally.
- MEM_LAT=3: pipe read. Expected ack in cycle 5 after grant; data captured from mem_dout in cycle 4.
